// File: rtl/ex_issue_stage.sv
// Execute-stage issue/capture unit in front of the ALU: holds operands and op, negates sub operands,
// captures the result with a true zero flag. Optional writeback forwarding is enabled by EX_ISSUE_FWD_EN.
module ex_issue_stage #(
   parameter int WIDTH    = 32,
   parameter int REG_BITS = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   input  logic [1:0]          in_alu_op,
   input  logic [REG_BITS-1:0] in_rd,
   input  logic [REG_BITS-1:0] in_rs1,
   input  logic [REG_BITS-1:0] in_rs2,
   output logic [WIDTH-1:0]    alu_a,
   output logic [WIDTH-1:0]    alu_b,
   output logic [1:0]          alu_op,
   input  logic [WIDTH-1:0]    alu_result,
   input  logic                alu_op_done,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_result,
   output logic                out_zero,
   output logic [REG_BITS-1:0] out_rd,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WAIT,
      FULL
   } state_t;

   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_NOP = 2'b11;

   state_t              state;
   state_t              state_next;
   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    b_q;
   logic [1:0]          op_q;
   logic [REG_BITS-1:0] rd_q;
   logic [WIDTH-1:0]    result_q;
   logic                zero_q;
   logic [REG_BITS-1:0] out_rd_q;

   logic                accept;
   logic                capture;
   logic                release_out;
   logic [WIDTH-1:0]    a_sel;
   logic [WIDTH-1:0]    b_sel;
   logic [WIDTH-1:0]    b_latch;
   logic [WIDTH-1:0]    capture_value;

   assign accept      = in_valid && in_ready;
   assign capture     = (state == WAIT) && alu_op_done;
   assign release_out = (state == FULL) && out_ready;

`ifdef EX_ISSUE_FWD_EN
   logic                fwd_valid;
   logic [WIDTH-1:0]    fwd_data;
   logic [REG_BITS-1:0] fwd_rd;

   // Remember the last result writeback actually took, so a dependent op can bypass the register file.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_valid <= 1'b0;
         fwd_data  <= '0;
         fwd_rd    <= '0;
      end else if (release_out) begin
         fwd_valid <= 1'b1;
         fwd_data  <= result_q;
         fwd_rd    <= out_rd_q;
      end
   end

   assign a_sel = (fwd_valid && (in_rs1 != '0) && (in_rs1 == fwd_rd)) ? fwd_data : in_a;
   assign b_sel = (fwd_valid && (in_rs2 != '0) && (in_rs2 == fwd_rd)) ? fwd_data : in_b;
`else
   logic unused_rs;

   assign unused_rs = ^{in_rs1, in_rs2};
   assign a_sel     = in_a;
   assign b_sel     = in_b;
`endif

   // The ALU adder has no carry-in, so subtraction is done by handing it the two's complement of b.
   assign b_latch       = (in_alu_op == OP_SUB) ? ((~b_sel) + WIDTH'(1)) : b_sel;
   assign capture_value = (op_q == OP_NOP) ? '0 : alu_result;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (alu_op_done) begin
               state_next = FULL;
            end
         end
         FULL: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_NOP;
         rd_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         out_rd_q <= '0;
      end else begin
         if (accept) begin
            a_q  <= a_sel;
            b_q  <= b_latch;
            op_q <= in_alu_op;
            rd_q <= in_rd;
         end
         if (capture) begin
            result_q <= capture_value;
            zero_q   <= (capture_value == '0);
            out_rd_q <= rd_q;
         end
      end
   end

   // Outside IDLE the held op stays on the ALU; in IDLE a nop keeps it quiet with op_done asserted.
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = (state == IDLE) ? OP_NOP : op_q;
   assign in_ready   = (state == IDLE);
   assign busy       = (state != IDLE);
   assign out_valid  = (state == FULL);
   assign out_result = result_q;
   assign out_zero   = zero_q;
   assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Randomized self-checking bench for ex_issue_stage with a behavioural ALU and a spec-level reference model.
module tb_ex_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [1:0]  in_alu_op = 2'b11;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [1:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_op_done;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_zero;
   logic [4:0]  out_rd;
   logic        busy;

   int checks = 0;
   int fails = 0;
   int mul_n = 0;
   int mul_cnt = 0;

   bit          m_fwd_valid = 1'b0;
   logic [31:0] m_fwd_data = '0;
   logic [4:0]  m_fwd_rd = '0;

   ex_issue_stage #(.WIDTH(32), .REG_BITS(5)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_a(in_a),
      .in_b(in_b),
      .in_alu_op(in_alu_op),
      .in_rd(in_rd),
      .in_rs1(in_rs1),
      .in_rs2(in_rs2),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_op(alu_op),
      .alu_result(alu_result),
      .alu_op_done(alu_op_done),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_result(out_result),
      .out_zero(out_zero),
      .out_rd(out_rd),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: adder with no carry-in, multiplier that keeps op_done low for mul_n wait cycles.
   always @(posedge clk) begin
      if (alu_op == 2'b10) mul_cnt <= mul_cnt + 1;
      else mul_cnt <= 0;
   end

   assign alu_result  = (alu_op == 2'b10) ? alu_a * alu_b :
                        (alu_op == 2'b11) ? (alu_a ^ alu_b) : alu_a + alu_b;
   assign alu_op_done = (alu_op != 2'b10) || (mul_cnt >= mul_n + 1);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] effOperand(input logic [31:0] v, input logic [4:0] rs);
      if (rs == 5'd0) return v;
`ifdef EX_ISSUE_FWD_EN
      if (m_fwd_valid && rs == m_fwd_rd) return m_fwd_data;
`endif
      return v;
   endfunction

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input int n, input int bp, input bit early);
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] exp_b;
      logic [31:0] exp_res;
      int cyc;
      ea    = effOperand(a, rs1);
      eb    = effOperand(b, rs2);
      exp_b = (op == 2'b01) ? (32'd0 - eb) : eb;
      case (op)
         2'b00:   exp_res = ea + eb;
         2'b01:   exp_res = ea - eb;
         2'b10:   exp_res = ea * eb;
         default: exp_res = 32'd0;
      endcase
      @(negedge clk);
      checkOutput("idle_ready", 32'(in_ready), 32'd1);
      checkOutput("idle_alu_op", 32'(alu_op), 32'd3);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_alu_op = op;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      mul_n     = n;
      out_ready = early;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("exec_busy", 32'(busy), 32'd1);
      checkOutput("exec_ready", 32'(in_ready), 32'd0);
      checkOutput("exec_alu_a", alu_a, ea);
      checkOutput("exec_alu_b", alu_b, exp_b);
      cyc = 0;
      while (!out_valid && cyc < 64) begin
         checkOutput("held_alu_op", 32'(alu_op), 32'(op));
         @(negedge clk);
         cyc++;
      end
      checkOutput("latency", 32'(cyc), 32'(2 + n));
      checkOutput("result", out_result, exp_res);
      checkOutput("zero", 32'(out_zero), 32'(exp_res == 32'd0));
      checkOutput("rd", 32'(out_rd), 32'(rd));
      for (int i = 0; i < bp; i++) begin
         in_valid  = 1'b1;
         in_a      = $urandom;
         in_alu_op = 2'b00;
         @(negedge clk);
         checkOutput("bp_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_ready", 32'(in_ready), 32'd0);
         checkOutput("bp_result", out_result, exp_res);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("release_valid", 32'(out_valid), 32'd0);
      checkOutput("release_alu_op", 32'(alu_op), 32'd3);
      checkOutput("release_ready", 32'(in_ready), 32'd1);
      m_fwd_valid = 1'b1;
      m_fwd_data  = exp_res;
      m_fwd_rd    = rd;
   endtask

   task automatic applyResetMidMul();
      @(negedge clk);
      in_valid  = 1'b1;
      in_a      = 32'd123;
      in_b      = 32'd456;
      in_alu_op = 2'b10;
      in_rd     = 5'd9;
      in_rs1    = 5'd0;
      in_rs2    = 5'd0;
      mul_n     = 20;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("mul_wait_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_alu_op", 32'(alu_op), 32'd3);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ready", 32'(in_ready), 32'd1);
      rst_n       = 1'b1;
      m_fwd_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_no_result", 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          early;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_result", out_result, 32'd0);
      checkOutput("reset_zero", 32'(out_zero), 32'd1);
      checkOutput("reset_rd", 32'(out_rd), 32'd0);
      checkOutput("reset_alu_a", alu_a, 32'd0);
      checkOutput("reset_alu_b", alu_b, 32'd0);
      checkOutput("reset_alu_op", 32'(alu_op), 32'd3);
      rst_n = 1'b1;

      applyStimulus(2'b00, 32'd5, 32'd7, 5'd1, 5'd0, 5'd0, 0, 0, 1'b0);
      applyStimulus(2'b01, 32'd9, 32'd9, 5'd2, 5'd0, 5'd0, 0, 0, 1'b0);
      applyStimulus(2'b01, 32'd3, 32'd5, 5'd2, 5'd0, 5'd0, 0, 0, 1'b0);
      applyStimulus(2'b10, 32'd6, 32'd7, 5'd5, 5'd0, 5'd0, 4, 0, 1'b0);
      applyStimulus(2'b11, 32'd8, 32'd8, 5'd6, 5'd0, 5'd0, 0, 0, 1'b0);
      applyStimulus(2'b00, 32'd100, 32'd23, 5'd7, 5'd0, 5'd0, 0, 5, 1'b0);
      applyStimulus(2'b00, 32'hFFFFFFFF, 32'd1, 5'd8, 5'd0, 5'd0, 0, 0, 1'b1);
      applyResetMidMul();
      applyStimulus(2'b00, 32'd1, 32'd1, 5'd1, 5'd0, 5'd0, 0, 0, 1'b0);
      applyStimulus(2'b00, 32'd4, 32'd6, 5'd3, 5'd0, 5'd0, 0, 0, 1'b0);
      applyStimulus(2'b00, 32'd0, 32'd1, 5'd4, 5'd3, 5'd0, 0, 0, 1'b0);
      applyStimulus(2'b00, 32'd0, 32'd1, 5'd4, 5'd0, 5'd0, 0, 0, 1'b0);
      applyStimulus(2'b01, 32'd50, 32'd2, 5'd4, 5'd0, 5'd4, 0, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         op    = 2'($urandom_range(0, 3));
         a     = ($urandom % 2 == 0) ? $urandom : 32'($urandom_range(0, 15));
         b     = ($urandom % 2 == 0) ? $urandom : 32'($urandom_range(0, 15));
         early = 1'($urandom % 2);
         applyStimulus(op, a, b, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), (op == 2'b10) ? $urandom_range(0, 5) : 0,
                       early ? 0 : $urandom_range(0, 3), early);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
